// File: rtl/square_pkg.sv
// square_pkg: shared types and register map for the square coordinate block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package square_pkg;

  typedef logic [10:0] coord_t;

  // Word offsets (byte address bits [4:2])
  localparam logic [2:0] OFS_X1     = 3'd0;
  localparam logic [2:0] OFS_X2     = 3'd1;
  localparam logic [2:0] OFS_Y1     = 3'd2;
  localparam logic [2:0] OFS_Y2     = 3'd3;
  localparam logic [2:0] OFS_CTRL   = 3'd4;
  localparam logic [2:0] OFS_STATUS = 3'd5;
  localparam logic [2:0] OFS_VEL    = 3'd6;

  // CTRL / STATUS bit positions
  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int CTRL_MOVE_BIT      = 1;
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_FCNT_LSB    = 16;

endpackage

// File: rtl/square_regs_if.sv
// square_regs_if: AHB-Lite slave-side bus bundle for square_regs.
// Latency: n/a (wires only).
// Backpressure: carried by HREADY/HREADYOUT.
interface square_regs_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/square_mover.sv
// square_mover: next position and bounce decision for one axis of the square.
// Latency: purely combinational.
// Backpressure: none; the caller decides on which frame edge to apply the result.
module square_mover
  import square_pkg::*;
#(
  parameter coord_t MAX = 11'd639
) (
  input  coord_t            lo,
  input  coord_t            hi,
  input  logic signed [7:0] d,
  output coord_t            lo_n,
  output coord_t            hi_n,
  output logic signed [7:0] d_n
);

  logic signed [11:0] d_w;
  logic signed [11:0] lo_w;
  logic signed [11:0] hi_w;
  logic               bounce;

  // 12-bit signed arithmetic so a step below column/row 0 shows up as negative
  assign d_w    = {{4{d[7]}}, d};
  assign lo_w   = $signed({1'b0, lo}) + d_w;
  assign hi_w   = $signed({1'b0, hi}) + d_w;
  assign bounce = lo_w[11] | (hi_w > $signed({1'b0, MAX}));

  // On a bounce the square stays put this frame and the velocity reverses
  assign lo_n = bounce ? lo : lo_w[10:0];
  assign hi_n = bounce ? hi : hi_w[10:0];
  assign d_n  = bounce ? -d : d;

endmodule

// File: rtl/square_regs.sv
// square_regs: AHB-Lite shadow/active registers for the VGA square, committed on the VS falling edge.
// Latency: zero-wait-state bus; committed values reach x1..y2 one HCLK after vs_in falls.
// Backpressure: none, HREADYOUT is always 1. Optional build macro SQUARE_AUTO_MOVE_EN adds VEL/MOVE bounce.
module square_regs
  import square_pkg::*;
#(
  parameter coord_t X1_RST = 11'd100,
  parameter coord_t X2_RST = 11'd200,
  parameter coord_t Y1_RST = 11'd100,
  parameter coord_t Y2_RST = 11'd200,
  parameter coord_t H_MAX  = 11'd639,
  parameter coord_t V_MAX  = 11'd479
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  square_regs_if.slave  bus,
  input  logic          vs_in,
  output coord_t        x1,
  output coord_t        x2,
  output coord_t        y1,
  output coord_t        y2
);

  logic        ph_vld;
  logic        ph_wr;
  logic [2:0]  ph_idx;
  logic        vs_d;
  logic        frame_edge;
  logic        wr_en;
  logic        commit;
  logic        pending;
  logic [15:0] frame_cnt;
  coord_t      sh_x1, sh_x2, sh_y1, sh_y2;
  logic [31:0] rdata;
  logic [31:0] ctrl_rd;
  logic [31:0] vel_rd;
  logic        move_edge;
  coord_t      mx1, mx2, my1, my2;
  logic        unused_ok;

  assign frame_edge = vs_d & ~vs_in;
  assign wr_en      = ph_vld & ph_wr & bus.HREADY;
  assign commit     = frame_edge & pending;

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  // Capture the address phase of a transfer addressed to this slave
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph_vld <= 1'b0;
      ph_wr  <= 1'b0;
      ph_idx <= 3'd0;
    end else if (bus.HREADY) begin
      ph_vld <= bus.HSEL & bus.HTRANS[1];
      ph_wr  <= bus.HWRITE;
      ph_idx <= bus.HADDR[4:2];
    end
  end

  // Delay vs_in one cycle for falling-edge detection
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) vs_d <= 1'b1;
    else          vs_d <= vs_in;
  end

  // Shadow coordinates written by software; a commit on the same edge sees the old value
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sh_x1 <= X1_RST;
      sh_x2 <= X2_RST;
      sh_y1 <= Y1_RST;
      sh_y2 <= Y2_RST;
    end else if (wr_en) begin
      case (ph_idx)
        OFS_X1:  sh_x1 <= bus.HWDATA[10:0];
        OFS_X2:  sh_x2 <= bus.HWDATA[10:0];
        OFS_Y1:  sh_y1 <= bus.HWDATA[10:0];
        OFS_Y2:  sh_y2 <= bus.HWDATA[10:0];
        default: ;
      endcase
    end
  end

  // Commit request: a new request beats the frame edge consuming the old one
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pending <= 1'b0;
    end else if (wr_en && ph_idx == OFS_CTRL && bus.HWDATA[CTRL_COMMIT_BIT]) begin
      pending <= 1'b1;
    end else if (frame_edge) begin
      pending <= 1'b0;
    end
  end

  // Free-running frame counter for software pacing, wraps at 16 bits
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)        frame_cnt <= 16'd0;
    else if (frame_edge) frame_cnt <= frame_cnt + 16'd1;
  end

`ifdef SQUARE_AUTO_MOVE_EN
  logic              move;
  logic signed [7:0] dx, dy;
  logic signed [7:0] dx_n, dy_n;

  // A commit on the same edge takes priority, so movement is suppressed while pending
  assign move_edge = frame_edge & move & ~pending;

  square_mover #(.MAX(H_MAX)) u_mover_x (
    .lo(x1), .hi(x2), .d(dx), .lo_n(mx1), .hi_n(mx2), .d_n(dx_n)
  );
  square_mover #(.MAX(V_MAX)) u_mover_y (
    .lo(y1), .hi(y2), .d(dy), .lo_n(my1), .hi_n(my2), .d_n(dy_n)
  );

  // MOVE enable bit, software R/W
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                           move <= 1'b0;
    else if (wr_en && ph_idx == OFS_CTRL)   move <= bus.HWDATA[CTRL_MOVE_BIT];
  end

  // Velocity: a software write wins over a bounce reversal in the same cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dx <= 8'sd0;
      dy <= 8'sd0;
    end else if (wr_en && ph_idx == OFS_VEL) begin
      dx <= bus.HWDATA[7:0];
      dy <= bus.HWDATA[15:8];
    end else if (move_edge) begin
      dx <= dx_n;
      dy <= dy_n;
    end
  end

  assign ctrl_rd   = {30'd0, move, 1'b0};
  assign vel_rd    = {16'd0, dy, dx};
  assign unused_ok = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA[31:16]};
`else
  assign move_edge = 1'b0;
  assign mx1       = x1;
  assign mx2       = x2;
  assign my1       = y1;
  assign my2       = y2;
  assign ctrl_rd   = 32'd0;
  assign vel_rd    = 32'd0;
  assign unused_ok = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA[31:11], H_MAX, V_MAX};
`endif

  // Active coordinates: load shadow on a committed frame edge, otherwise step when moving
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      x1 <= X1_RST;
      x2 <= X2_RST;
      y1 <= Y1_RST;
      y2 <= Y2_RST;
    end else if (commit) begin
      x1 <= sh_x1;
      x2 <= sh_x2;
      y1 <= sh_y1;
      y2 <= sh_y2;
    end else if (move_edge) begin
      x1 <= mx1;
      x2 <= mx2;
      y1 <= my1;
      y2 <= my2;
    end
  end

  // Read mux over the captured address; zero outside a read data phase
  always_comb begin
    rdata = 32'd0;
    if (ph_vld && !ph_wr) begin
      case (ph_idx)
        OFS_X1:     rdata = {21'd0, sh_x1};
        OFS_X2:     rdata = {21'd0, sh_x2};
        OFS_Y1:     rdata = {21'd0, sh_y1};
        OFS_Y2:     rdata = {21'd0, sh_y2};
        OFS_CTRL:   rdata = ctrl_rd;
        OFS_STATUS: rdata = {frame_cnt, 15'd0, pending};
        OFS_VEL:    rdata = vel_rd;
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_square_regs.sv
// tb_square_regs: directed stimulus for square_regs with a transaction-level reference model.
// The model tracks shadow/active/pending/frame count from bus and vs_in activity; a negedge
// process compares outputs every cycle, and directed reads pin the model with literal values.
module tb_square_regs;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b1;
  logic        vs_in   = 1'b1;
  logic [10:0] x1, x2, y1, y2;

  square_regs_if bus();

  square_regs dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus),
    .vs_in   (vs_in),
    .x1      (x1),
    .x2      (x2),
    .y1      (y1),
    .y2      (y2)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_shadow[4];
  int  m_active[4];
  bit  m_pending;
  bit  m_move;
  int  m_frames;
  byte m_dx, m_dy;
  bit  m_vs_prev;
  bit  m_ph_vld, m_ph_wr;
  int  m_ph_idx;

  function automatic void model_reset();
    m_shadow  = '{100, 200, 100, 200};
    m_active  = '{100, 200, 100, 200};
    m_pending = 0;
    m_move    = 0;
    m_frames  = 0;
    m_dx      = 0;
    m_dy      = 0;
    m_vs_prev = 1;
    m_ph_vld  = 0;
    m_ph_wr   = 0;
    m_ph_idx  = 0;
  endfunction

  function automatic void step(inout int lo, inout int hi, inout byte d, input int mx);
    int nl, nh;
    nl = lo + int'(d);
    nh = hi + int'(d);
    if (nl < 0 || nh > mx) d = -d;
    else begin
      lo = nl;
      hi = nh;
    end
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    logic [31:0] f;
    f = m_frames;
    case (idx)
      0, 1, 2, 3: return m_shadow[idx];
      4:          return {30'd0, m_move, 1'b0};
      5:          return {f[15:0], 15'd0, m_pending};
      6:          return {16'd0, m_dy, m_dx};
      default:    return 32'd0;
    endcase
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    bit fe;
    bit old_pend, old_move;
    int old_sh[4];
    if (!HRESETn) begin
      model_reset();
    end else begin
      fe        = m_vs_prev && !vs_in;
      m_vs_prev = vs_in;
      old_sh    = m_shadow;
      old_pend  = m_pending;
      old_move  = m_move;
      if (fe) begin
        m_frames = (m_frames + 1) % 65536;
        if (old_pend) begin
          m_active  = old_sh;
          m_pending = 0;
        end else if (old_move) begin
          step(m_active[0], m_active[1], m_dx, 639);
          step(m_active[2], m_active[3], m_dy, 479);
        end
      end
      if (m_ph_vld && m_ph_wr && bus.HREADY) begin
        case (m_ph_idx)
          0, 1, 2, 3: m_shadow[m_ph_idx] = int'(bus.HWDATA[10:0]);
          4: begin
            if (bus.HWDATA[0]) m_pending = 1;
`ifdef SQUARE_AUTO_MOVE_EN
            m_move = bus.HWDATA[1];
`endif
          end
          6: begin
`ifdef SQUARE_AUTO_MOVE_EN
            m_dx = bus.HWDATA[7:0];
            m_dy = bus.HWDATA[15:8];
`endif
          end
          default: ;
        endcase
      end
      if (bus.HREADY) begin
        m_ph_vld = bus.HSEL && bus.HTRANS[1];
        m_ph_wr  = bus.HWRITE;
        m_ph_idx = int'(bus.HADDR[4:2]);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge HCLK) begin
    check("x1", {21'd0, x1}, m_active[0]);
    check("x2", {21'd0, x2}, m_active[1]);
    check("y1", {21'd0, y1}, m_active[2]);
    check("y2", {21'd0, y2}, m_active[3]);
    check("hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    check("hresp", {31'd0, bus.HRESP}, 32'd0);
    if (m_ph_vld && !m_ph_wr) check("hrdata", bus.HRDATA, m_read(m_ph_idx));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_bus();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'd0;
    bus.HSIZE  = 3'b010;
    bus.HREADY = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    tick(1);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = w;
    bus.HADDR  = a;
  endtask

  // Leaves the bench inside the data phase; the write lands on the next rising edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    tick(1);
    idle_bus();
    bus.HWDATA = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    addr_phase(a, 1'b0);
    tick(1);
    idle_bus();
    @(negedge HCLK);
    check(nm, bus.HRDATA, exp);
  endtask

  // One VS pulse; the falling edge is sampled on the first rising edge after vs_in drops
  task automatic frame();
    tick(1);
    vs_in = 1'b0;
    tick(2);
    vs_in = 1'b1;
    tick(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    bus.HWDATA = 32'd0;
    #1 HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Reset state
    @(negedge HCLK);
    check("rst_x1", {21'd0, x1}, 32'd100);
    check("rst_x2", {21'd0, x2}, 32'd200);
    check("rst_y1", {21'd0, y1}, 32'd100);
    check("rst_y2", {21'd0, y2}, 32'd200);
    check("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
    rd(32'h14, 32'h0000_0000, "rst_status");

    // Commit held off while vs_in stays high
    wr(32'h00, 32'd300);
    wr(32'h04, 32'd400);
    wr(32'h10, 32'h1);
    tick(100);
    @(negedge HCLK);
    check("hold_x1", {21'd0, x1}, 32'd100);
    rd(32'h14, 32'h0000_0001, "pending_status");
    tick(1);
    vs_in = 1'b0;
    @(negedge HCLK);
    check("pre_edge_x1", {21'd0, x1}, 32'd100);
    @(negedge HCLK);
    check("commit_x1", {21'd0, x1}, 32'd300);
    check("commit_x2", {21'd0, x2}, 32'd400);
    tick(2);
    vs_in = 1'b1;
    tick(2);
    rd(32'h14, 32'h0001_0000, "status_frame1");

    // COMMIT data phase coincides with the frame edge: deferred one frame
    wr(32'h00, 32'd50);
    addr_phase(32'h10, 1'b1);
    tick(1);
    idle_bus();
    bus.HWDATA = 32'h1;
    vs_in = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    check("coinc_commit_x1", {21'd0, x1}, 32'd300);
    tick(1);
    vs_in = 1'b1;
    tick(2);
    rd(32'h14, 32'h0002_0001, "coinc_status");
    frame();
    @(negedge HCLK);
    check("late_commit_x1", {21'd0, x1}, 32'd50);
    rd(32'h14, 32'h0003_0000, "late_status");

    // Shadow write coinciding with the frame edge: commit takes the old value
    wr(32'h0C, 32'd250);
    wr(32'h10, 32'h1);
    addr_phase(32'h0C, 1'b1);
    tick(1);
    idle_bus();
    bus.HWDATA = 32'd260;
    vs_in = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    check("coinc_y2", {21'd0, y2}, 32'd250);
    tick(1);
    vs_in = 1'b1;
    tick(2);
    rd(32'h0C, 32'd260, "shadow_y2_new");

    // Masking, unmapped offsets, CTRL/VEL readback
    wr(32'h08, 32'hFFFF_F7FF);
    rd(32'h08, 32'h0000_07FF, "y1_mask");
    rd(32'h1C, 32'h0000_0000, "unmapped_rd");
    wr(32'h1C, 32'hDEAD_BEEF);
    rd(32'h00, 32'd50, "unmapped_wr_x1");
    rd(32'h04, 32'd400, "unmapped_wr_x2");
    wr(32'h10, 32'h2);
`ifdef SQUARE_AUTO_MOVE_EN
    rd(32'h10, 32'h0000_0002, "ctrl_move_rd");
`else
    rd(32'h10, 32'h0000_0000, "ctrl_move_rd");
`endif
    wr(32'h10, 32'h0);
    wr(32'h18, 32'h0000_0305);
`ifdef SQUARE_AUTO_MOVE_EN
    rd(32'h18, 32'h0000_0305, "vel_rd");
`else
    rd(32'h18, 32'h0000_0000, "vel_rd");
`endif
    wr(32'h18, 32'h0);

    // y1 > y2 is committed unchanged
    wr(32'h10, 32'h1);
    frame();
    @(negedge HCLK);
    check("inverted_y1", {21'd0, y1}, 32'h7FF);
    check("inverted_y2", {21'd0, y2}, 32'd260);

    // Frame counting and 16-bit wrap
    repeat (10) frame();
    rd(32'h14, 32'h000F_0000, "fcnt_15");
    @(negedge HCLK);
    #1;
    force dut.frame_cnt = 16'hFFFE;
    m_frames = 65534;
    #1;
    release dut.frame_cnt;
    frame();
    rd(32'h14, 32'hFFFF_0000, "fcnt_ffff");
    frame();
    rd(32'h14, 32'h0000_0000, "fcnt_wrap");

    // Reset in the middle of a write to X2 drops the write
    addr_phase(32'h04, 1'b1);
    tick(1);
    idle_bus();
    bus.HWDATA = 32'd999;
    #2 HRESETn = 1'b0;
    @(negedge HCLK);
    check("midrst_x2", {21'd0, x2}, 32'd200);
    tick(1);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("postrst_x1", {21'd0, x1}, 32'd100);
    check("postrst_x2", {21'd0, x2}, 32'd200);
    rd(32'h04, 32'd200, "postrst_shadow_x2");
    rd(32'h14, 32'h0000_0000, "postrst_status");

`ifdef SQUARE_AUTO_MOVE_EN
    // Bounce at the right edge, then move left
    wr(32'h00, 32'd630);
    wr(32'h04, 32'd635);
    wr(32'h10, 32'h1);
    frame();
    @(negedge HCLK);
    check("mv_start_x1", {21'd0, x1}, 32'd630);
    wr(32'h18, 32'h0000_0005);
    wr(32'h10, 32'h2);
    frame();
    @(negedge HCLK);
    check("mv_bounce_x1", {21'd0, x1}, 32'd630);
    check("mv_bounce_x2", {21'd0, x2}, 32'd635);
    rd(32'h18, 32'h0000_00FB, "mv_bounce_vel");
    frame();
    @(negedge HCLK);
    check("mv_step_x1", {21'd0, x1}, 32'd625);
    check("mv_step_x2", {21'd0, x2}, 32'd630);
    check("mv_step_y1", {21'd0, y1}, 32'd100);
    wr(32'h10, 32'h0);
`endif

    tick(3);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
